// File: rtl/cache_ctrl_fsm_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the L1 cache controller:
//   - state_e      : controller state encoding
//   - POLICY_*     : write-policy encodings
//   - calc_ww()    : way-index width for a given associativity
//   - calc_bw()    : beat-index width for a given line length in words
// -----------------------------------------------------------------------------
package cache_pkg;

    typedef enum logic [2:0] {
        ST_CHECK  = 3'd0,
        ST_WRBACK = 3'd1,
        ST_FILL   = 3'd2,
        ST_UPDATE = 3'd3,
        ST_WTHRU  = 3'd4
    } state_e;

    localparam bit POLICY_WT = 1'b0;   // write-through, no allocate on store miss
    localparam bit POLICY_WB = 1'b1;   // write-back, write-allocate

    // A direct-mapped cache still carries a 1-bit way index.
    function automatic int calc_ww(input int ways);
        if (ways <= 1) begin
            return 1;
        end else begin
            return $clog2(ways);
        end
    endfunction

    function automatic int calc_bw(input int words);
        return $clog2(words);
    endfunction

endpackage

// File: rtl/cache_ctrl_fsm_beat_counter.sv
// -----------------------------------------------------------------------------
// beat_counter
// BW-bit word counter for multi-beat line transfers.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   clr_i        : return to beat 0 (has priority over inc_i)
//   inc_i        : advance one beat
//   cnt_o        : current beat index
//   last_o       : current beat is the final word of the line
// -----------------------------------------------------------------------------
module beat_counter #(
    parameter int BW = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [BW-1:0] cnt_o,
    output logic          last_o
);

    logic [BW-1:0] cnt_q;
    logic [BW-1:0] cnt_d;

    // Next-count selection: clear wins over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {BW{1'b0}};
        end else if (inc_i) begin
            cnt_d = cnt_q + {{(BW-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= {BW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Lines are a power of two words long, so the last beat is all ones.
    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == {BW{1'b1}});

endmodule

// File: rtl/cache_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// cache_ctrl_fsm
// L1 cache controller: hit/miss classification, dirty-line write-back,
// multi-beat refill and single-beat write-through.
// Ports:
//   CLK, RST            : clock, asynchronous active-high reset
//   cpu_req, cpu_we     : CPU access valid / access is a store
//   cpu_offset          : word offset of the CPU access (write-through beat)
//   hit, hit_way        : tag match and matching way
//   victim_way/_dirty   : replacement way and its dirty bit
//   mem_ack             : memory finished current beat
//   cpu_stall           : pipeline hold
//   mem_req, mem_we     : memory beat request / write
//   beat                : word index of current memory beat
//   way_sel             : way addressed by array writes
//   cache_we, fill_sel  : data-array word write, source (1 = memory)
//   set_valid, set_dirty, clr_dirty, lru_update : tag/LRU strobes
// Outputs are decoded combinationally so a hit completes in its own cycle;
// they are all forced low while RST is asserted.
// -----------------------------------------------------------------------------
module cache_ctrl_fsm
    import cache_pkg::*;
#(
    parameter  int WAYS       = 2,
    parameter  int WORDS      = 4,
    parameter  int WRITE_BACK = 1,
    localparam int WW         = calc_ww(WAYS),
    localparam int BW         = calc_bw(WORDS)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [BW-1:0] cpu_offset,
    input  logic          hit,
    input  logic [WW-1:0] hit_way,
    input  logic [WW-1:0] victim_way,
    input  logic          victim_dirty,
    input  logic          mem_ack,
    output logic          cpu_stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [BW-1:0] beat,
    output logic [WW-1:0] way_sel,
    output logic          cache_we,
    output logic          fill_sel,
    output logic          set_valid,
    output logic          set_dirty,
    output logic          clr_dirty,
    output logic          lru_update
);

    localparam bit POLICY = (WRITE_BACK != 0) ? POLICY_WB : POLICY_WT;

    state_e        state_q, state_d;
    logic [WW-1:0] way_q, way_d;
    logic [BW-1:0] off_q, off_d;

    logic          cnt_clr_s, cnt_inc_s, cnt_last_s;
    logic [BW-1:0] cnt_s;

    logic          stall_s, mem_req_s, mem_we_s, cache_we_s, fill_sel_s;
    logic          set_valid_s, set_dirty_s, clr_dirty_s, lru_update_s;
    logic [BW-1:0] beat_s;
    logic [WW-1:0] way_sel_s;

    beat_counter #(.BW(BW)) u_beat_counter (
        .clk_i  (CLK),
        .rst_i  (RST),
        .clr_i  (cnt_clr_s),
        .inc_i  (cnt_inc_s),
        .cnt_o  (cnt_s),
        .last_o (cnt_last_s)
    );

    // Next-state and output decode.
    always_comb begin
        state_d      = state_q;
        way_d        = way_q;
        off_d        = off_q;
        cnt_clr_s    = 1'b0;
        cnt_inc_s    = 1'b0;
        stall_s      = 1'b0;
        mem_req_s    = 1'b0;
        mem_we_s     = 1'b0;
        cache_we_s   = 1'b0;
        fill_sel_s   = 1'b0;
        set_valid_s  = 1'b0;
        set_dirty_s  = 1'b0;
        clr_dirty_s  = 1'b0;
        lru_update_s = 1'b0;
        beat_s       = cnt_s;
        way_sel_s    = way_q;

        case (state_q)
            ST_CHECK: begin
                if (!cpu_req) begin
                    state_d = ST_CHECK;
                end else if (hit) begin
                    lru_update_s = 1'b1;
                    way_sel_s    = hit_way;
                    if (cpu_we) begin
                        cache_we_s = 1'b1;
                        fill_sel_s = 1'b0;
                        if (POLICY == POLICY_WB) begin
                            set_dirty_s = 1'b1;
                        end else begin
                            // Array updated now; memory copy follows in WTHRU.
                            stall_s = 1'b1;
                            off_d   = cpu_offset;
                            state_d = ST_WTHRU;
                        end
                    end else begin
                        state_d = ST_CHECK;
                    end
                end else begin
                    stall_s   = 1'b1;
                    way_d     = victim_way;
                    way_sel_s = victim_way;
                    if ((POLICY == POLICY_WB) && victim_dirty) begin
                        state_d = ST_WRBACK;
                    end else if ((POLICY == POLICY_WT) && cpu_we) begin
                        off_d   = cpu_offset;
                        state_d = ST_WTHRU;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
            end
            ST_WRBACK: begin
                stall_s   = 1'b1;
                mem_req_s = 1'b1;
                mem_we_s  = 1'b1;
                if (mem_ack) begin
                    if (cnt_last_s) begin
                        cnt_clr_s   = 1'b1;
                        clr_dirty_s = 1'b1;
                        state_d     = ST_FILL;
                    end else begin
                        cnt_inc_s = 1'b1;
                    end
                end else begin
                    state_d = ST_WRBACK;
                end
            end
            ST_FILL: begin
                stall_s   = 1'b1;
                mem_req_s = 1'b1;
                if (mem_ack) begin
                    cache_we_s = 1'b1;
                    fill_sel_s = 1'b1;
                    if (cnt_last_s) begin
                        cnt_clr_s = 1'b1;
                        state_d   = ST_UPDATE;
                    end else begin
                        cnt_inc_s = 1'b1;
                    end
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_UPDATE: begin
                stall_s     = 1'b1;
                set_valid_s = 1'b1;
                state_d     = ST_CHECK;
            end
            ST_WTHRU: begin
                mem_req_s = 1'b1;
                mem_we_s  = 1'b1;
                beat_s    = off_q;
                if (mem_ack) begin
                    stall_s = 1'b0;
                    state_d = ST_CHECK;
                end else begin
                    stall_s = 1'b1;
                end
            end
            default: begin
                cnt_clr_s = 1'b1;
                state_d   = ST_CHECK;
            end
        endcase
    end

    // State, latched victim way and write-through offset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_CHECK;
            way_q   <= {WW{1'b0}};
            off_q   <= {BW{1'b0}};
        end else begin
            state_q <= state_d;
            way_q   <= way_d;
            off_q   <= off_d;
        end
    end

    // Request-gated decode must not leak out while reset is held.
    assign cpu_stall  = RST ? 1'b0 : stall_s;
    assign mem_req    = RST ? 1'b0 : mem_req_s;
    assign mem_we     = RST ? 1'b0 : mem_we_s;
    assign beat       = RST ? {BW{1'b0}} : beat_s;
    assign way_sel    = RST ? {WW{1'b0}} : way_sel_s;
    assign cache_we   = RST ? 1'b0 : cache_we_s;
    assign fill_sel   = RST ? 1'b0 : fill_sel_s;
    assign set_valid  = RST ? 1'b0 : set_valid_s;
    assign set_dirty  = RST ? 1'b0 : set_dirty_s;
    assign clr_dirty  = RST ? 1'b0 : clr_dirty_s;
    assign lru_update = RST ? 1'b0 : lru_update_s;

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_cache_ctrl_fsm
// Directed bench for cache_ctrl_fsm: one write-back and one write-through
// instance (WAYS=2, WORDS=4) share the stimulus; each scenario resets first
// where the other instance's state matters.
// -----------------------------------------------------------------------------
module tb_cache_ctrl_fsm;

    logic       CLK = 1'b0;
    logic       RST;
    logic       cpu_req, cpu_we, hit, victim_dirty, mem_ack;
    logic [0:0] hit_way, victim_way;
    logic [1:0] cpu_offset;

    logic       stall_b, mem_req_b, mem_we_b, cache_we_b, fill_sel_b;
    logic       set_valid_b, set_dirty_b, clr_dirty_b, lru_b;
    logic [1:0] beat_b;
    logic [0:0] way_sel_b;

    logic       stall_t, mem_req_t, mem_we_t, cache_we_t, fill_sel_t;
    logic       set_valid_t, set_dirty_t, clr_dirty_t, lru_t;
    logic [1:0] beat_t;
    logic [0:0] way_sel_t;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    cache_ctrl_fsm #(.WAYS(2), .WORDS(4), .WRITE_BACK(1)) dut_wb (
        .CLK(CLK), .RST(RST), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_offset(cpu_offset), .hit(hit), .hit_way(hit_way),
        .victim_way(victim_way), .victim_dirty(victim_dirty), .mem_ack(mem_ack),
        .cpu_stall(stall_b), .mem_req(mem_req_b), .mem_we(mem_we_b),
        .beat(beat_b), .way_sel(way_sel_b), .cache_we(cache_we_b),
        .fill_sel(fill_sel_b), .set_valid(set_valid_b), .set_dirty(set_dirty_b),
        .clr_dirty(clr_dirty_b), .lru_update(lru_b)
    );

    cache_ctrl_fsm #(.WAYS(2), .WORDS(4), .WRITE_BACK(0)) dut_wt (
        .CLK(CLK), .RST(RST), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_offset(cpu_offset), .hit(hit), .hit_way(hit_way),
        .victim_way(victim_way), .victim_dirty(victim_dirty), .mem_ack(mem_ack),
        .cpu_stall(stall_t), .mem_req(mem_req_t), .mem_we(mem_we_t),
        .beat(beat_t), .way_sel(way_sel_t), .cache_we(cache_we_t),
        .fill_sel(fill_sel_t), .set_valid(set_valid_t), .set_dirty(set_dirty_t),
        .clr_dirty(clr_dirty_t), .lru_update(lru_t)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic req, input logic we, input logic h,
                         input logic hw, input logic vw, input logic vd,
                         input logic ack, input logic [1:0] off);
        cpu_req = req; cpu_we = we; hit = h; hit_way = hw;
        victim_way = vw; victim_dirty = vd; mem_ack = ack; cpu_offset = off;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        tick();
        tick();
        RST = 1'b0;
    endtask

    int stall_cnt, wr_n, rd_n, clr_n, clr_c, sv_c, sv_n, sd_n;

    initial begin
        // ---------------- reset state ----------------
        RST = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd3);
        #2;
        chk("rst_stall",    stall_b,    0);
        chk("rst_mem_req",  mem_req_b,  0);
        chk("rst_cache_we", cache_we_b, 0);
        chk("rst_lru",      lru_b,      0);
        chk("rst_way_sel",  way_sel_b,  0);
        tick();
        tick();
        RST = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        @(negedge CLK);
        chk("idle_stall", stall_b, 0);
        chk("idle_lru",   lru_b,   0);
        chk("idle_mreq",  mem_req_b, 0);
        tick();

        // ---------------- load hit, way 1 ----------------
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        @(negedge CLK);
        chk("ldhit_stall",   stall_b,    0);
        chk("ldhit_lru",     lru_b,      1);
        chk("ldhit_way",     way_sel_b,  1);
        chk("ldhit_mreq",    mem_req_b,  0);
        chk("ldhit_cwe",     cache_we_b, 0);
        tick();

        // ---------------- store hit, write-back ----------------
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1);
        @(negedge CLK);
        chk("sthit_stall", stall_b,     0);
        chk("sthit_cwe",   cache_we_b,  1);
        chk("sthit_fsel",  fill_sel_b,  0);
        chk("sthit_dirty", set_dirty_b, 1);
        chk("sthit_way",   way_sel_b,   0);
        tick();

        // ---------------- clean load miss, ack every cycle ----------------
        // Ack in cycle 0 must be ignored (no request yet); cpu_req drops mid-fill.
        stall_cnt = 0;
        for (int c = 0; c <= 6; c++) begin
            drive((c == 0) || (c == 6), 1'b0, (c == 6), 1'b1, 1'b1, 1'b0,
                  (c <= 4), 2'd0);
            @(negedge CLK);
            stall_cnt += int'(stall_b);
            if (c == 0) begin
                chk("cm_c0_stall", stall_b,   1);
                chk("cm_c0_way",   way_sel_b, 1);
                chk("cm_c0_mreq",  mem_req_b, 0);
            end else if (c <= 4) begin
                chk("cm_mreq",  mem_req_b,  1);
                chk("cm_mwe",   mem_we_b,   0);
                chk("cm_beat",  beat_b,     c - 1);
                chk("cm_cwe",   cache_we_b, 1);
                chk("cm_fsel",  fill_sel_b, 1);
                chk("cm_way",   way_sel_b,  1);
            end else if (c == 5) begin
                chk("cm_upd_valid", set_valid_b, 1);
                chk("cm_upd_stall", stall_b,     1);
                chk("cm_upd_mreq",  mem_req_b,   0);
            end else begin
                chk("cm_hit_stall", stall_b, 0);
                chk("cm_hit_lru",   lru_b,   1);
            end
            tick();
        end
        chk("cm_stall_cycles", stall_cnt, 6);

        // ---------------- dirty miss, ack every 2nd cycle ----------------
        stall_cnt = 0; wr_n = 0; rd_n = 0; clr_n = 0; clr_c = -1; sv_c = -1;
        for (int c = 0; c <= 17; c++) begin
            drive(1'b1, 1'b0, (c == 17), 1'b0, 1'b0, 1'b1, c[0], 2'd0);
            @(negedge CLK);
            stall_cnt += int'(stall_b);
            if (mem_req_b && mem_ack) begin
                if (mem_we_b) begin
                    chk("dm_wr_beat", beat_b, wr_n);
                    wr_n++;
                end else begin
                    chk("dm_rd_beat", beat_b, rd_n);
                    rd_n++;
                end
            end
            if (clr_dirty_b) begin
                clr_n++;
                clr_c = c;
            end
            if (set_valid_b) sv_c = c;
            tick();
        end
        chk("dm_stall_cycles", stall_cnt, 17);
        chk("dm_wr_beats",     wr_n,      4);
        chk("dm_rd_beats",     rd_n,      4);
        chk("dm_clr_count",    clr_n,     1);
        chk("dm_clr_cycle",    clr_c,     7);
        chk("dm_valid_cycle",  sv_c,      16);

        // ---------------- reset during fill beat 2 ----------------
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        tick();
        sv_n = 0;
        for (int c = 0; c <= 3; c++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, (c >= 1), 2'd0);
            @(negedge CLK);
            sv_n += int'(set_valid_b);
            if (c == 3) chk("rf_pre_beat", beat_b, 2);
            if (c < 3) tick();
        end
        #1;
        RST = 1'b1;
        #1;
        chk("rf_async_mreq",  mem_req_b,  0);
        chk("rf_async_stall", stall_b,    0);
        chk("rf_async_cwe",   cache_we_b, 0);
        tick();
        RST = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        @(negedge CLK);
        sv_n += int'(set_valid_b);
        chk("rf_idle_stall", stall_b,   0);
        chk("rf_idle_mreq",  mem_req_b, 0);
        tick();
        for (int c = 0; c <= 3; c++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, (c >= 2), 2'd0);
            @(negedge CLK);
            sv_n += int'(set_valid_b);
            if (c == 0) chk("rf_new_stall", stall_b, 1);
            if (c == 1) chk("rf_new_hold_beat", beat_b, 0);
            if (c == 2) chk("rf_new_beat0", beat_b, 0);
            if (c == 3) chk("rf_new_beat1", beat_b, 1);
            if (c >= 1) chk("rf_new_mreq", mem_req_b, 1);
            tick();
        end
        chk("rf_no_set_valid", sv_n, 0);

        // ---------------- write-through instance ----------------
        do_reset();
        sd_n = 0;
        for (int c = 0; c <= 6; c++) begin
            case (c)
                0, 1:    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2);
                2:       drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2);
                4:       drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd3);
                5:       drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0);
                default: drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
            endcase
            @(negedge CLK);
            sd_n += int'(set_dirty_t);
            case (c)
                0: begin
                    chk("wt_hit_cwe",   cache_we_t, 1);
                    chk("wt_hit_fsel",  fill_sel_t, 0);
                    chk("wt_hit_lru",   lru_t,      1);
                    chk("wt_hit_way",   way_sel_t,  1);
                    chk("wt_hit_stall", stall_t,    1);
                end
                1: begin
                    chk("wt_wait_mreq",  mem_req_t,  1);
                    chk("wt_wait_mwe",   mem_we_t,   1);
                    chk("wt_wait_beat",  beat_t,     2);
                    chk("wt_wait_stall", stall_t,    1);
                    chk("wt_wait_cwe",   cache_we_t, 0);
                end
                2: begin
                    chk("wt_ack_stall", stall_t,   0);
                    chk("wt_ack_mreq",  mem_req_t, 1);
                end
                3: begin
                    chk("wt_done_mreq",  mem_req_t, 0);
                    chk("wt_done_stall", stall_t,   0);
                end
                4: begin
                    chk("wt_miss_stall", stall_t,    1);
                    chk("wt_miss_cwe",   cache_we_t, 0);
                    chk("wt_miss_mreq",  mem_req_t,  0);
                end
                5: begin
                    chk("wt_miss_beat",  beat_t,   3);
                    chk("wt_miss_mwe",   mem_we_t, 1);
                    chk("wt_miss_stall", stall_t,  0);
                end
                default: begin
                    chk("wt_end_mreq", mem_req_t, 0);
                end
            endcase
            tick();
        end
        chk("wt_no_set_dirty", sd_n, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
